// File: rtl/reg_bus_reader_if.sv
// Bundle of request, select/bus and response signals between reg_bus_reader and its users.
// req and rsp are valid/ready channels: a word moves on a Tick edge where valid & ready, and valid holds its payload until then.
interface reg_bus_reader_if #(
    parameter int NrOfBits   = 32,
    parameter int NrOfSlaves = 4,
    parameter int AddrBits   = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic [AddrBits-1:0]   req_addr;
    logic [NrOfSlaves-1:0] cs_n;
    logic [NrOfBits-1:0]   bus_in;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [NrOfBits-1:0]   rsp_data;
    logic                  rsp_err;

    modport master (
        input  req_valid, req_addr, bus_in, rsp_ready,
        output req_ready, cs_n, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_addr, bus_in, rsp_ready,
        input  req_ready, cs_n, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/reg_bus_reader.sv
// Read master for the shared tri-state register bus: selects one slave, lets the bus
// settle for TurnCycles, samples it and returns the word on a valid/ready response.
module reg_bus_reader #(
    parameter int NrOfBits   = 32,
    parameter int NrOfSlaves = 4,
    parameter int AddrBits   = 2,
    parameter int TurnCycles = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Tick,
    reg_bus_reader_if.master     bus,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {IDLE, SELECT, SAMPLE, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [NrOfSlaves-1:0] cs_n_q, cs_n_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [NrOfBits-1:0]   rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [NrOfSlaves-1:0] sel_mask;
    logic                  addr_ok;

    assign addr_ok = int'(bus.req_addr) < NrOfSlaves;

    always_comb begin
        sel_mask = '1;
        for (int i = 0; i < NrOfSlaves; i++) begin
            sel_mask[i] = (int'(bus.req_addr) != i);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cs_n_d      = cs_n_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                cs_n_d = '1;
                if (bus.req_valid) begin
                    if (addr_ok) begin
                        state_d = SELECT;
                        cs_n_d  = sel_mask;
                        cnt_d   = 4'(TurnCycles);
                    end else begin
                        // Out-of-range address: answer immediately, never touch the bus.
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            SELECT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = SAMPLE;
            end
            SAMPLE: begin
                rsp_data_d  = bus.bus_in;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                cs_n_d      = '1;
                state_d     = RESP;
            end
            RESP: begin
                cs_n_d = '1;
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset releases the bus immediately; Tick gates every register update.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cs_n_q      <= '1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else if (Tick) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.cs_n      = cs_n_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign state_dbg     = state_q;
endmodule
